cb_search_ctrl: RTL and testbench

CB_SEARCH_CTRL -- requirements
Module: cb_search_ctrl

---
 rtl/cb_search_ctrl.sv | 120 ++++++++++++
 tb/tb_cb_search_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cb_search_ctrl.sv
// cb_search_ctrl: nearest-neighbour codebook search controller.
//
// Purpose: on an accepted start, walks a combinational codebook ROM from
// address 0 to DEPTH-1, one entry per cycle. It keeps the entry with the
// smallest absolute distance to the latched target, then pulses done for
// one cycle. Words are signed Q15.16 fixed point.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   search request, sampled only while idle
//   target     in   N   value to quantise, captured with start
//   rom_addr   out  AW  codebook ROM address (ROM answers in the same cycle)
//   rom_data   in   N   codebook entry at rom_addr
//   busy       out  high during SEARCH and DONE
//   done       out  one-cycle pulse when best_index/best_value are valid
//   best_index out  AW  index of the nearest entry
//   best_value out  N   codebook entry at best_index
module cb_search_ctrl #(
  parameter int N     = 32,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  target,
  output logic [AW-1:0] rom_addr,
  input  logic [N-1:0]  rom_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] best_index,
  output logic [N-1:0]  best_value
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  localparam logic [AW-1:0] last_addr = AW'(DEPTH - 1);
  localparam logic [N:0]    one_w     = {{N{1'b0}}, 1'b1};

  state_t        state_reg;
  logic [N-1:0]  target_reg;
  logic [N:0]    best_err_reg;
  logic [AW-1:0] rom_addr_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [AW-1:0] best_index_reg;
  logic [N-1:0]  best_value_reg;

  // The distance is formed one bit wider than the operands. A difference
  // of two N-bit signed values always fits in N+1 signed bits. Its magnitude
  // is at most 2^N, and that fits in N+1 unsigned bits, so nothing can
  // overflow.
  logic [N:0] diff;
  logic [N:0] err;

  assign diff = {target_reg[N-1], target_reg} - {rom_data[N-1], rom_data};
  assign err  = diff[N] ? (~diff + one_w) : diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      target_reg     <= '0;
      best_err_reg   <= '1;
      rom_addr_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      best_index_reg <= '0;
      best_value_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            target_reg   <= target;
            rom_addr_reg <= '0;
            // All-ones guarantees that the first entry read wins.
            best_err_reg <= '1;
            busy_reg     <= 1'b1;
            state_reg    <= SEARCH;
          end
        end
        SEARCH: begin
          // A strict compare means a tie keeps the earlier (lower) index.
          if (err < best_err_reg) begin
            best_err_reg   <= err;
            best_index_reg <= rom_addr_reg;
            best_value_reg <= rom_data;
          end
          if (rom_addr_reg == last_addr) begin
            rom_addr_reg <= '0;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end else begin
            rom_addr_reg <= rom_addr_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr   = rom_addr_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign best_index = best_index_reg;
  assign best_value = best_value_reg;

endmodule

// File: tb/tb_cb_search_ctrl.sv
// Testbench for cb_search_ctrl. The ROM holds entry i = (1500 + 100*i) in
// Q15.16. The stimulus pushes the expected result and the done cycle into
// a scoreboard. A monitor pops an entry and compares it on every done pulse.
module tb_cb_search_ctrl;

  localparam int N     = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  target;
  logic [AW-1:0] rom_addr;
  logic [N-1:0]  rom_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] best_index;
  logic [N-1:0]  best_value;

  typedef struct {
    int          idx;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  cb_search_ctrl #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .target     (target),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .best_index (best_index),
    .best_value (best_value)
  );

  // Combinational codebook ROM.
  assign rom_data = (32'd1500 + 32'd100 * 32'(rom_addr)) << 16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("best_index", 64'(best_index), 64'(e.idx));
        chk("best_value", 64'(best_value), 64'(e.val));
        $display("txn: done cycle=%0d index=%0d value=0x%08h", cyc, best_index, best_value);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits with a bounded cycle budget until the scoreboard drains.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic run_search(input logic [31:0] t, input int ei, input logic [31:0] ev);
    start  = 1'b1;
    target = t;
    sb.push_back('{idx: ei, val: ev, cyc: cyc + 17});
    step();
    start = 1'b0;
    wait_drain(40);
  endtask

  initial begin
    int t0;
    rst    = 1'b1;
    start  = 1'b0;
    target = '0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_index", 64'(best_index), 64'd0);
    chk("rst_value", 64'(best_value), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;
    step();

    // Plain nearest, tie, just-past-tie, and the range extremes.
    run_search(32'h0801_0000, 5, 32'h07D0_0000);   // 2049.0
    run_search(32'h0802_0000, 5, 32'h07D0_0000);   // 2050.0 tie
    run_search(32'h0802_0001, 6, 32'h0834_0000);   // 2050.0 + 2^-16
    run_search(32'hFF9C_0000, 0, 32'h05DC_0000);   // -100.0
    run_search(32'h7FFF_0000, 15, 32'h0BB8_0000);  // 32767.0
    run_search(32'h8000_0000, 0, 32'h05DC_0000);   // most negative
    run_search(32'h7FFF_FFFF, 15, 32'h0BB8_0000);  // most positive

    // Reset in mid-search aborts it: no done pulse, outputs clear.
    t0     = cyc;
    start  = 1'b1;
    target = 32'h0801_0000;
    step();
    start = 1'b0;
    while (cyc < t0 + 8) step();
    rst = 1'b1;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_index", 64'(best_index), 64'd0);
    chk("abort_value", 64'(best_value), 64'd0);
    chk("abort_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;
    repeat (20) step();
    run_search(32'h0BB8_0000, 15, 32'h0BB8_0000);  // 3000.0

    // Start re-pulsed while busy and target changed in mid-search: both
    // are ignored, and the address sweep is 0..15 exactly once.
    t0     = cyc;
    start  = 1'b1;
    target = 32'h0801_0000;
    sb.push_back('{idx: 5, val: 32'h07D0_0000, cyc: t0 + 17});
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k <= 16) chk("sweep_addr", 64'(rom_addr), 64'(k - 1));
      if (k == 1 || k == 6 || k == 18) start = 1'b0;
      if (k == 5) begin
        start  = 1'b1;
        target = 32'hFF9C_0000;
      end
      if (k == 17) start = 1'b1;
      if (k == 18) begin
        chk("repulse_busy", 64'(busy), 64'd0);
        chk("repulse_hold_index", 64'(best_index), 64'd5);
        chk("repulse_idle_addr", 64'(rom_addr), 64'd0);
      end
    end
    repeat (20) step();
    chk("repulse_busy_after", 64'(busy), 64'd0);
    chk("repulse_pending", 64'(sb.size()), 64'd0);

    // Start held high for 40 cycles: searches back to back, with busy low
    // for a single cycle between them.
    t0     = cyc;
    start  = 1'b1;
    target = 32'h0801_0000;
    sb.push_back('{idx: 5, val: 32'h07D0_0000, cyc: t0 + 17});
    sb.push_back('{idx: 5, val: 32'h07D0_0000, cyc: t0 + 35});
    sb.push_back('{idx: 5, val: 32'h07D0_0000, cyc: t0 + 53});
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 40) start = 1'b0;
      if (k <= 35) chk("held_busy", 64'(busy), (k == 18) ? 64'd0 : 64'd1);
    end
    wait_drain(40);

    chk("final_pending", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
